// File: rtl/play_mode_arbiter_pkg.sv
// Shared mode encodings, FSM state type and helpers for the play-mode arbiter.
package play_mode_pkg;

    localparam logic [2:0] MODE_FREE  = 3'b100;
    localparam logic [2:0] MODE_AUTO  = 3'b010;
    localparam logic [2:0] MODE_LEARN = 3'b001;
    localparam logic [2:0] MODE_NONE  = 3'b000;
    localparam logic [3:0] NOTE_REST  = 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        RUN  = 2'd2
    } state_t;

    // A switch setting is only meaningful when exactly one player is selected.
    function automatic logic is_onehot3(input logic [2:0] m);
        return (m == MODE_FREE) || (m == MODE_AUTO) || (m == MODE_LEARN);
    endfunction

endpackage

// File: rtl/play_mode_arbiter_if.sv
// Bundle of player inputs and arbitrated outputs between the players and the drivers.
interface play_mode_arbiter_if;

    logic [2:0] mode;
    logic [3:0] free_note;
    logic [6:0] free_led;
    logic [1:0] free_octave;
    logic [3:0] auto_note;
    logic [6:0] auto_led;
    logic [1:0] auto_octave;
    logic [3:0] auto_num;
    logic [3:0] learn_note;
    logic [6:0] learn_led;
    logic [1:0] learn_octave;
    logic [3:0] learn_num;

    logic [3:0] note_out;
    logic [6:0] led_out;
    logic [1:0] octave_out;
    logic [3:0] num;
    logic [2:0] active_mode;
    logic       muted;
    logic       auto_restart;
    logic       learn_restart;

    modport master (
        output mode,
        output free_note, free_led, free_octave,
        output auto_note, auto_led, auto_octave, auto_num,
        output learn_note, learn_led, learn_octave, learn_num,
        input  note_out, led_out, octave_out, num,
        input  active_mode, muted, auto_restart, learn_restart
    );

    modport slave (
        input  mode,
        input  free_note, free_led, free_octave,
        input  auto_note, auto_led, auto_octave, auto_num,
        input  learn_note, learn_led, learn_octave, learn_num,
        output note_out, led_out, octave_out, num,
        output active_mode, muted, auto_restart, learn_restart
    );

endinterface

// File: rtl/play_mode_arbiter_debouncer.sv
// Mode switch debouncer: flags the edge on which a setting has been seen
// DEBOUNCE_CYCLES times in a row, and reports that setting.
module mode_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] mode_in,
    output logic [2:0] stable_mode,
    output logic       change_pulse
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [2:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    stable_q;
    logic          pulse_q, pulse_d;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (mode_in == cand_q) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cand_d = mode_in;
            cnt_d  = CNT_ONE;
        end
        // Fire only on arrival at the threshold, not while sitting saturated.
        pulse_d = (cnt_d == CNT_MAX) && ((cnt_q != CNT_MAX) || (mode_in != cand_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q   <= 3'b000;
            cnt_q    <= '0;
            stable_q <= 3'b000;
            pulse_q  <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            if (pulse_d) begin
                stable_q <= cand_d;
            end
        end
    end

    assign stable_mode  = stable_q;
    assign change_pulse = pulse_q;

endmodule

// File: rtl/play_mode_arbiter.sv
// Hands the shared note/LED/octave/digit outputs between the free, auto and
// learn players, with a muted gap and a restart pulse on every handover.
module play_mode_arbiter
    import play_mode_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int GAP_CYCLES      = 5000000
) (
    input  logic                clk,
    input  logic                reset,
    play_mode_arbiter_if.slave  bus
);

    localparam int            GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic [2:0]    req_mode;
    logic          req_pulse;
    logic [2:0]    cmp_target;
    logic          req_valid, req_invalid;

    state_t        state_q;
    logic [2:0]    target_q;
    logic [GW-1:0] gap_cnt_q;
    logic [3:0]    note_q;
    logic [6:0]    led_q;
    logic [1:0]    octave_q;
    logic [3:0]    num_q;
    logic [2:0]    active_q;
    logic          muted_q;
    logic          auto_rst_q;
    logic          learn_rst_q;

    logic [3:0]    src_note;
    logic [6:0]    src_led;
    logic [1:0]    src_octave;
    logic [3:0]    src_num;

    mode_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk          (clk),
        .reset        (reset),
        .mode_in      (bus.mode),
        .stable_mode  (req_mode),
        .change_pulse (req_pulse)
    );

    // During a gap a request is judged against where we are heading, not the silent owner.
    always_comb begin
        cmp_target  = (state_q == GAP) ? target_q : active_q;
        req_valid   = req_pulse && (req_mode != cmp_target) && is_onehot3(req_mode);
        req_invalid = req_pulse && (req_mode != cmp_target) && !is_onehot3(req_mode);
    end

    always_comb begin
        src_note   = NOTE_REST;
        src_led    = '0;
        src_octave = '0;
        src_num    = '0;
        case (active_q)
            MODE_FREE: begin
                src_note   = bus.free_note;
                src_led    = bus.free_led;
                src_octave = bus.free_octave;
            end
            MODE_AUTO: begin
                src_note   = bus.auto_note;
                src_led    = bus.auto_led;
                src_octave = bus.auto_octave;
                src_num    = bus.auto_num;
            end
            MODE_LEARN: begin
                src_note   = bus.learn_note;
                src_led    = bus.learn_led;
                src_octave = bus.learn_octave;
                src_num    = bus.learn_num;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            target_q    <= MODE_NONE;
            gap_cnt_q   <= '0;
            note_q      <= NOTE_REST;
            led_q       <= '0;
            octave_q    <= '0;
            num_q       <= '0;
            active_q    <= MODE_NONE;
            muted_q     <= 1'b0;
            auto_rst_q  <= 1'b0;
            learn_rst_q <= 1'b0;
        end else begin
            auto_rst_q  <= 1'b0;
            learn_rst_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    note_q   <= NOTE_REST;
                    led_q    <= '0;
                    octave_q <= '0;
                    num_q    <= '0;
                    active_q <= MODE_NONE;
                    muted_q  <= 1'b0;
                    if (req_valid) begin
                        state_q   <= GAP;
                        target_q  <= req_mode;
                        gap_cnt_q <= '0;
                        muted_q   <= 1'b1;
                    end
                end
                GAP: begin
                    // Octave is deliberately left alone so the tone generator keeps its range.
                    note_q   <= NOTE_REST;
                    led_q    <= '0;
                    num_q    <= '0;
                    active_q <= MODE_NONE;
                    if (req_invalid) begin
                        state_q  <= IDLE;
                        target_q <= MODE_NONE;
                        octave_q <= '0;
                        muted_q  <= 1'b0;
                    end else if (req_valid) begin
                        target_q  <= req_mode;
                        gap_cnt_q <= '0;
                        muted_q   <= 1'b1;
                    end else if (gap_cnt_q == GAP_LAST) begin
                        state_q     <= RUN;
                        muted_q     <= 1'b0;
                        active_q    <= target_q;
                        auto_rst_q  <= (target_q == MODE_AUTO);
                        learn_rst_q <= (target_q == MODE_LEARN);
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                        muted_q   <= 1'b1;
                    end
                end
                RUN: begin
                    muted_q <= 1'b0;
                    if (req_valid) begin
                        state_q   <= GAP;
                        target_q  <= req_mode;
                        gap_cnt_q <= '0;
                        muted_q   <= 1'b1;
                        active_q  <= MODE_NONE;
                        note_q    <= NOTE_REST;
                        led_q     <= '0;
                        num_q     <= '0;
                    end else if (req_invalid) begin
                        state_q  <= IDLE;
                        target_q <= MODE_NONE;
                        active_q <= MODE_NONE;
                        note_q   <= NOTE_REST;
                        led_q    <= '0;
                        octave_q <= '0;
                        num_q    <= '0;
                    end else begin
                        note_q   <= src_note;
                        led_q    <= src_led;
                        octave_q <= src_octave;
                        num_q    <= src_num;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.note_out      = note_q;
    assign bus.led_out       = led_q;
    assign bus.octave_out    = octave_q;
    assign bus.num           = num_q;
    assign bus.active_mode   = active_q;
    assign bus.muted         = muted_q;
    assign bus.auto_restart  = auto_rst_q;
    assign bus.learn_restart = learn_rst_q;

endmodule

// File: tb/tb_play_mode_arbiter.sv
// Scoreboard bench for play_mode_arbiter: a timestamp-based ownership model
// predicts every cycle's outputs, a monitor compares them against the DUT.
module tb_play_mode_arbiter;
    import play_mode_pkg::*;

    localparam int DEB  = 4;
    localparam int GAPC = 3;

    typedef struct packed {
        logic [3:0] note;
        logic [6:0] led;
        logic [1:0] octave;
        logic [3:0] num;
        logic [2:0] active;
        logic       muted;
        logic       ar;
        logic       lr;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    play_mode_arbiter_if bus();

    play_mode_arbiter #(
        .DEBOUNCE_CYCLES(DEB),
        .GAP_CYCLES     (GAPC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: who owns the outputs, where a gap is heading, and when it ends.
    int         edge_n    = 0;
    int         stable_len = 0;
    logic [2:0] last_mode = 3'b000;
    logic       pend      = 1'b0;
    logic [2:0] pend_mode = 3'b000;
    logic [2:0] owner     = 3'b000;
    logic [2:0] heading   = 3'b000;
    int         gap_until = 0;
    int         run_since = -1;
    obs_t       exp_prev  = '0;

    task automatic model_edge(output obs_t e);
        logic [2:0] tgt;
        edge_n++;
        e = '0;
        if (reset) begin
            stable_len = 0;
            last_mode  = 3'b000;
            pend       = 1'b0;
            owner      = 3'b000;
            heading    = 3'b000;
            run_since  = -1;
        end else begin
            tgt = (heading != 3'b000) ? heading : owner;
            if (pend && pend_mode != tgt) begin
                owner = 3'b000;
                if ($countones(pend_mode) == 1) begin
                    heading   = pend_mode;
                    gap_until = edge_n + GAPC;
                end else begin
                    heading = 3'b000;
                end
            end else if (heading != 3'b000 && edge_n == gap_until) begin
                owner     = heading;
                heading   = 3'b000;
                run_since = edge_n;
            end
            pend = 1'b0;
            if (bus.mode == last_mode) begin
                if (stable_len < DEB) begin
                    stable_len++;
                    pend = (stable_len == DEB);
                end
            end else begin
                last_mode  = bus.mode;
                stable_len = 1;
                pend       = (DEB == 1);
            end
            pend_mode = bus.mode;

            e.muted  = (heading != 3'b000);
            e.active = owner;
            e.ar     = (owner == MODE_AUTO)  && (run_since == edge_n);
            e.lr     = (owner == MODE_LEARN) && (run_since == edge_n);
            if (owner != 3'b000 && run_since != edge_n) begin
                if (owner == MODE_FREE) begin
                    e.note = bus.free_note; e.led = bus.free_led; e.octave = bus.free_octave;
                end else if (owner == MODE_AUTO) begin
                    e.note = bus.auto_note; e.led = bus.auto_led; e.octave = bus.auto_octave;
                    e.num = bus.auto_num;
                end else begin
                    e.note = bus.learn_note; e.led = bus.learn_led; e.octave = bus.learn_octave;
                    e.num = bus.learn_num;
                end
            end else if (heading != 3'b000 || owner != 3'b000) begin
                e.octave = exp_prev.octave;
            end
        end
        exp_prev = e;
    endtask

    task automatic drive_cycle(input logic [2:0] m, input logic r);
        obs_t e;
        @(negedge clk);
        reset            = r;
        bus.mode         = m;
        bus.free_note    = 4'($urandom);
        bus.free_led     = 7'($urandom);
        bus.free_octave  = 2'($urandom);
        bus.auto_note    = 4'($urandom);
        bus.auto_led     = 7'($urandom);
        bus.auto_octave  = 2'($urandom);
        bus.auto_num     = 4'($urandom);
        bus.learn_note   = 4'($urandom);
        bus.learn_led    = 7'($urandom);
        bus.learn_octave = 2'($urandom);
        bus.learn_num    = 4'($urandom);
        model_edge(e);
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [2:0] m, input int cycles);
        for (int i = 0; i < cycles; i++) drive_cycle(m, 1'b0);
    endtask

    // Monitor: every clock produces one output word, compared against the oldest prediction.
    initial begin
        obs_t e, got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {bus.note_out, bus.led_out, bus.octave_out, bus.num,
                       bus.active_mode, bus.muted, bus.auto_restart, bus.learn_restart};
                n_cmp++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL outputs t=%0t got note=%0d led=%h oct=%0d num=%0d act=%b mute=%b ar=%b lr=%b required note=%0d led=%h oct=%0d num=%0d act=%b mute=%b ar=%b lr=%b",
                             $time, got.note, got.led, got.octave, got.num, got.active, got.muted, got.ar, got.lr,
                             e.note, e.led, e.octave, e.num, e.active, e.muted, e.ar, e.lr);
                end else begin
                    $display("cmp t=%0t note=%0d act=%b mute=%b ar=%b lr=%b ok",
                             $time, got.note, got.active, got.muted, got.ar, got.lr);
                end
            end
        end
    end

    initial begin
        logic [2:0] m;
        int         wait_cyc;
        reset    = 1'b1;
        bus.mode = 3'b000;
        drive_cycle(3'b000, 1'b1);
        drive_cycle(3'b000, 1'b1);

        hold(MODE_AUTO, 12);                          // first handover into auto
        hold(MODE_FREE, 12);                          // into free
        hold(MODE_LEARN, 2);                          // short glitch, ignored
        hold(MODE_FREE, 10);
        hold(MODE_AUTO, 12);
        hold(MODE_LEARN, 12);                         // auto -> learn
        hold(MODE_AUTO, 12);
        hold(MODE_LEARN, 5);                          // into gap toward learn ...
        hold(MODE_FREE, 14);                          // ... retargeted to free
        hold(MODE_LEARN, 12);
        hold(3'b011, 8);                              // invalid -> silence
        hold(MODE_FREE, 12);
        hold(MODE_AUTO, 5);                           // reset lands mid-gap
        drive_cycle(MODE_AUTO, 1'b1);
        hold(MODE_AUTO, 14);

        for (int s = 0; s < 300; s++) begin
            case ($urandom_range(0, 9))
                0:       m = 3'($urandom);
                1, 2, 3: m = MODE_FREE;
                4, 5, 6: m = MODE_AUTO;
                default: m = MODE_LEARN;
            endcase
            if ($urandom_range(0, 40) == 0) drive_cycle(m, 1'b1);
            hold(m, $urandom_range(1, 12));
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/play_mode_arbiter.md
Name: play_mode_arbiter

Overview:
Sequences ownership of the shared note/LED/octave/digit outputs between the free, auto and learn players. It debounces the one-hot mode switches and inserts a muted gap on every handover. It then restarts the incoming player and passes its outputs through registered. Sits between the three player blocks and the buzzer/LED/7-seg drivers, replacing direct mode muxing.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive identical mode samples required before a change is accepted (10 ms at 100 MHz); minimum 1
GAP_CYCLES, 5000000, length of muted handover gap in clk cycles (50 ms); minimum 1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mode  in  3  raw mode switches: 100 free, 010 auto, 001 learn
free_note  in  4  free-player note code (0 = rest)
free_led  in  7  free-player LED pattern
free_octave  in  2  free-player octave
auto_note / auto_led / auto_octave / auto_num  in  4/7/2/4  auto-player outputs
learn_note / learn_led / learn_octave / learn_num  in  4/7/2/4  learn-player outputs
note_out  out  4  note to tone generator
led_out  out  7  LED pattern
octave_out  out  2  octave to tone generator
num  out  4  digit for 7-seg
active_mode  out  3  mode currently owning outputs (000 = none)
muted  out  1  high during handover gap
auto_restart  out  1  one-cycle pulse: restart auto player from song start
learn_restart  out  1  one-cycle pulse: restart learn player

Behaviour:
- Reset (sync, clk edge with reset=1): state IDLE; all outputs 0; debounce candidate=000, counter=0. Reset dominates every other event, including mid-gap.
- Debounce: each edge, if mode==candidate, increment counter, saturating at DEBOUNCE_CYCLES. Otherwise load candidate=mode and counter=1.
- Switch request (1 cycle): raised when counter reaches DEBOUNCE_CYCLES on this edge and candidate != target. target = active_mode in IDLE/RUN, latched target in GAP.
- Validity: exactly one bit set. 000, 011, 111 etc. are invalid.
- FSM IDLE: outputs 0, active_mode=000. Valid request -> GAP, latch target. Invalid request ignored.
- FSM GAP: muted=1; note_out=0, led_out=0, num=0, octave_out held; active_mode=000.
  - Gap counter runs GAP_CYCLES cycles, then -> RUN with active_mode=target.
  - Valid request during GAP: retarget and restart the gap counter.
  - Invalid request -> IDLE.
- FSM RUN: muted=0; outputs = selected source registered, 1-cycle latency. In free mode num=0.
  - Valid request -> GAP. Invalid request -> IDLE (silence).
- Restart pulses: asserted for exactly the first RUN cycle when target is auto/learn. Never asserted for free. Never both at once.
- Return to the same mode after a brief glitch shorter than DEBOUNCE_CYCLES: no request, no gap.
- Counters sized $clog2(param+1); no wrap; saturate.
- Timing: mode stable from edge E -> request at edge E+DEBOUNCE_CYCLES-1 -> GAP starts next edge -> RUN GAP_CYCLES edges later.

Decomposition:
- Package play_mode_pkg: MODE_FREE=3'b100, MODE_AUTO=3'b010, MODE_LEARN=3'b001, MODE_NONE=3'b000, NOTE_REST=4'd0, state enum {IDLE, GAP, RUN}, helper function is_onehot3.
- Sub-module mode_debouncer: (clk, reset, mode_in, stable_mode, change_pulse), parameter DEBOUNCE_CYCLES.
- FSM, gap counter and output mux live in the top.

Test Plan (DEBOUNCE_CYCLES=4, GAP_CYCLES=3):
1. Reset, then mode=010 held, auto_note=5 -> muted high exactly 3 cycles starting 4 cycles after mode set. auto_restart pulses 1 cycle on first RUN cycle; note_out=5 one cycle later; active_mode=010.
2. RUN free (free_note=7), mode glitches 100->001->100 for 2 cycles -> no request; muted stays 0; note_out stays 7.
3. RUN auto, mode->001 -> gap of 3 muted cycles with note_out=0, led_out=0, num=0; learn_restart pulses once; auto_restart stays 0; num follows learn_num.
4. In GAP toward learn, mode->100 and held -> gap restarts, full 3 cycles; ends in free with no restart pulses.
5. RUN learn, mode->011 held 4 cycles -> IDLE, all outputs 0, active_mode=000. Then mode->100 -> normal gap -> free.
6. Assert reset mid-GAP -> next edge: IDLE, muted=0, all outputs 0. Deassert with mode still 010 -> full debounce + gap before RUN.
